freq_report_formatter: RTL and testbench

Converts each frequency measurement (binary count) into a decimal ASCII line and feeds it byte-by-byte to the UART transmitter stage. Sits between the measurement core and the serial transmitter. Drives the transmitter's `start`/`data` inputs and paces itself on the transmitter's `busy` output. Uses an iterative double-dabble binary-to-BCD conversion, leading-zero suppression and a line terminator.

---
 rtl/freq_report_formatter_if.sv | 23 ++
 rtl/freq_report_formatter.sv | 143 ++++++++++++++
 tb/tb_freq_report_formatter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_report_formatter_if.sv
// Handshake bundle between the measurement core, the report formatter and the UART transmitter.
// slave: the formatter itself; master: its surroundings (measurement core and transmitter).
interface freq_report_formatter_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] value;
  logic             value_valid;
  logic             ready;
  logic             overrun;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_busy;

  modport slave (
    input  value, value_valid, tx_busy,
    output ready, overrun, tx_start, tx_data
  );

  modport master (
    output value, value_valid, tx_busy,
    input  ready, overrun, tx_start, tx_data
  );
endinterface

// File: rtl/freq_report_formatter.sv
// Binary frequency count -> decimal ASCII line, paced byte-by-byte on the UART busy flag.
// Define FREQ_REPORT_CRLF_EN to terminate lines with CR LF; otherwise LF only.
//
// state     | meaning
// IDLE      | ready for a new value
// CONVERT   | double-dabble, one bit per cycle for WIDTH cycles
// SKIP      | walk past leading zero digits (digit 0 always sent)
// SEND_REQ  | present byte with tx_start until tx_busy is seen high
// SEND_WAIT | wait for tx_busy low, then pick the next character
module freq_report_formatter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  freq_report_formatter_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int IW = $clog2(DIGITS);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [2:0] {
    S_IDLE, S_CONVERT, S_SKIP, S_SEND_REQ, S_SEND_WAIT
  } state_t;

  state_t           state;
  logic [BW-1:0]    bcd;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic             in_term;
`ifdef FREQ_REPORT_CRLF_EN
  logic             term_idx;
`endif
  logic             ready_q, overrun_q, tx_start_q;
  logic [7:0]       tx_data_q;

  logic [BW-1:0]    bcd_adj;
  logic [3:0]       cur_digit;
  logic [7:0]       term_char, cur_char;
  logic             last_term;

  assign bus.ready    = ready_q;
  assign bus.overrun  = overrun_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;

  always_comb begin
    bcd_adj   = '0;
    cur_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
      if (idx == IW'(i)) cur_digit = bcd[4*i +: 4];
    end
`ifdef FREQ_REPORT_CRLF_EN
    term_char = term_idx ? 8'h0A : 8'h0D;
    last_term = term_idx;
`else
    term_char = 8'h0A;
    last_term = 1'b1;
`endif
    cur_char = in_term ? term_char : {4'h3, cur_digit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      bcd        <= '0;
      shreg      <= '0;
      cnt        <= '0;
      idx        <= '0;
      in_term    <= 1'b0;
`ifdef FREQ_REPORT_CRLF_EN
      term_idx   <= 1'b0;
`endif
      ready_q    <= 1'b1;
      overrun_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      // ready_q is high exactly in IDLE, so this flags every dropped strobe
      overrun_q <= bus.value_valid && !ready_q;
      case (state)
        S_IDLE: begin
          if (bus.value_valid) begin
            shreg   <= bus.value;
            bcd     <= '0;
            cnt     <= CW'(WIDTH - 1);
            ready_q <= 1'b0;
            state   <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          {bcd, shreg} <= {bcd_adj, shreg} << 1;
          if (cnt == '0) begin
            idx   <= IW'(DIGITS - 1);
            state <= S_SKIP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_SKIP: begin
          if (cur_digit == 4'd0 && idx != '0) begin
            idx <= idx - 1'b1;
          end else begin
            in_term <= 1'b0;
`ifdef FREQ_REPORT_CRLF_EN
            term_idx <= 1'b0;
`endif
            state <= S_SEND_REQ;
          end
        end
        S_SEND_REQ: begin
          if (!tx_start_q) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= cur_char;
          end else if (bus.tx_busy) begin
            tx_start_q <= 1'b0;
            state      <= S_SEND_WAIT;
          end
        end
        S_SEND_WAIT: begin
          if (!bus.tx_busy) begin
            if (!in_term) begin
              if (idx == '0) in_term <= 1'b1;
              else           idx     <= idx - 1'b1;
              state <= S_SEND_REQ;
            end else if (last_term) begin
              ready_q <= 1'b1;
              state   <= S_IDLE;
            end else begin
`ifdef FREQ_REPORT_CRLF_EN
              term_idx <= 1'b1;
`endif
              state <= S_SEND_REQ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_freq_report_formatter.sv
// Self-checking bench: transmitter model with programmable busy delay/length, decimal reference model.
module tb_freq_report_formatter;
  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  freq_report_formatter_if #(.WIDTH(WIDTH)) bus ();

  freq_report_formatter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int bdelay = 5;
  int blen   = 20;
  logic tx_idle = 1'b1;
  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  int exp_first;

  // reference: plain decimal formatting of the value
  function automatic void make_expected(input logic [31:0] v);
    logic [7:0] d[$];
    logic [31:0] t;
    t = v;
    expq.delete();
    do begin
      d.push_front(8'h30 + 8'(t % 10));
      t = t / 10;
    end while (t != 0);
    foreach (d[i]) expq.push_back(d[i]);
    exp_first = WIDTH + (DIGITS - d.size()) + 2;
`ifdef FREQ_REPORT_CRLF_EN
    expq.push_back(8'h0D);
`endif
    expq.push_back(8'h0A);
  endfunction

  // transmitter: raises busy bdelay cycles after seeing start, holds it blen cycles
  initial begin
    logic [7:0] b;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        tx_idle = 1'b0;
        b = bus.tx_data;
        repeat (bdelay) @(negedge clk);
        rxq.push_back(b);
        bus.tx_busy = 1'b1;
        repeat (blen) @(negedge clk);
        bus.tx_busy = 1'b0;
        tx_idle = 1'b1;
      end
    end
  end

  task automatic start_line(input logic [31:0] v, input string name);
    int k;
    make_expected(v);
    @(negedge clk);
    bus.value = v;
    bus.value_valid = 1'b1;
    @(negedge clk);
    bus.value_valid = 1'b0;
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_after_accept got=%b want=0", name, bus.ready);
    end
    k = 0;
    while (bus.tx_start !== 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != exp_first) begin
      errors++;
      $display("FAIL %s first_start_edge got=E%0d want=E%0d", name, k, exp_first);
    end
  endtask

  task automatic finish_line(input string name);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 50000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_return got=%b want=1", name, bus.ready);
    end
    checks++;
    if (rxq.size() != expq.size()) begin
      errors++;
      $display("FAIL %s byte_count got=%0d want=%0d", name, rxq.size(), expq.size());
    end else begin
      foreach (expq[i]) begin
        checks++;
        if (rxq[i] !== expq[i]) begin
          errors++;
          $display("FAIL %s byte[%0d] got=%h want=%h", name, i, rxq[i], expq[i]);
        end
      end
    end
    rxq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.value = '0;
    bus.value_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.ready, bus.overrun, bus.tx_start, bus.tx_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs got=%b%b%b_%h want=100_00",
               bus.ready, bus.overrun, bus.tx_start, bus.tx_data);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero();
    bdelay = 5; blen = 20;
    start_line(32'd0, "zero");
    finish_line("zero");
  endtask

  task automatic test_digits();
    bdelay = 2; blen = 4;
    start_line(32'd1234567, "v1234567");
    finish_line("v1234567");
    start_line(32'hFFFF_FFFF, "vmax");
    finish_line("vmax");
  endtask

  task automatic test_slow_busy();
    logic [7:0] b0;
    int bad;
    bdelay = 200; blen = 3;
    start_line(32'd90210, "slow");
    b0 = bus.tx_data;
    bad = 0;
    repeat (199) begin
      @(negedge clk);
      if (bus.tx_start !== 1'b1 || bus.tx_data !== b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL slow_hold unstable_cycles got=%0d want=0", bad);
    end
    finish_line("slow");
  endtask

  task automatic test_overrun();
    int n;
    bdelay = 2; blen = 20;
    start_line(32'd4711, "overrun");
    n = 0;
    while (!(bus.tx_busy === 1'b1 && bus.tx_start === 1'b0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    bus.value = 32'd99;
    bus.value_valid = 1'b1;
    @(negedge clk);
    bus.value_valid = 1'b0;
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_pulse got=%b want=1", bus.overrun);
    end
    @(negedge clk);
    checks++;
    if (bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_one_cycle got=%b want=0", bus.overrun);
    end
    finish_line("overrun");
    repeat (80) @(negedge clk);
    checks++;
    if (rxq.size() != 0) begin
      errors++;
      $display("FAIL overrun_dropped extra_bytes got=%0d want=0", rxq.size());
    end
    rxq.delete();
  endtask

  task automatic test_reset_midline();
    int n;
    bdelay = 3; blen = 10;
    start_line(32'd1234567, "rst_mid");
    n = 0;
    while (rxq.size() < 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.ready, bus.overrun, bus.tx_start, bus.tx_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL midline_reset_outputs got=%b%b%b_%h want=100_00",
               bus.ready, bus.overrun, bus.tx_start, bus.tx_data);
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (tx_idle !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    rxq.delete();
    start_line(32'd7, "after_rst");
    finish_line("after_rst");
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int i = 0; i < 8; i++) begin
      v = $urandom() >> $urandom_range(0, 31);
      bdelay = $urandom_range(1, 8);
      blen   = $urandom_range(1, 6);
      start_line(v, $sformatf("rand%0d", i));
      finish_line($sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_digits();
    test_slow_busy();
    test_overrun();
    test_reset_midline();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
